// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative unsigned shift-and-add multiplier.
//
// The operands are captured when start is accepted. The product appears
// exactly WIDTH cycles later, with a single-cycle done pulse. The cycle
// count is fixed and does not depend on operand values.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request pulse; operands are sampled on the same edge
//   multiplicand  unsigned operand A (WIDTH bits)
//   multiplier    unsigned operand B (WIDTH bits)
//   busy          high while a multiply is in progress
//   done          one-cycle pulse when product is valid
//   product       A*B (2*WIDTH bits), held until the next completion or reset
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no operation; start launches a new multiply
// RUN   | one add/shift step per cycle; start is ignored
// DONE  | product just written, done high; start is accepted here too
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product_q;
  logic [CW-1:0]      cnt_q;
  logic               accept;
  logic               last_step;

  // start is honoured only outside RUN; a request in RUN is simply dropped
  assign accept    = start && (state_q != RUN);
  // terminal count: this edge performs the final iteration
  assign last_step = (state_q == RUN) && (cnt_q == CW'(1));
  assign acc_next  = b_q[0] ? (acc_q + a_q) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (cnt_q == CW'(1)) ? DONE : RUN;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_q   <= {{WIDTH{1'b0}}, multiplicand};
      b_q   <= multiplier;
      acc_q <= '0;
      cnt_q <= CW'(WIDTH);
    end else if (state_q == RUN) begin
      acc_q <= acc_next;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CW'(1);
      // the final step's add is folded in, so product is never partial
      if (last_step) begin
        product_q <= acc_next;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int total;
  int bad;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // Launches one operation from a negedge and returns at the negedge where
  // done is seen (or when the budget runs out). Only gathers observations;
  // each test judges them. Operands are scrambled while busy, and an
  // optional extra start can be injected n cycles after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int inj_n, input logic [31:0] ia, input logic [31:0] ib,
                        output int lat, output logic [63:0] prod,
                        output int overlap, output int busy_drop, output int prod_moved);
    logic [63:0] prev;
    int n;
    prev         = product;
    overlap      = 0;
    busy_drop    = 0;
    prod_moved   = 0;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    lat = -1;
    while (n < 100) begin
      if (busy && done) overlap++;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_drop++;
      if (product !== prev) prod_moved++;
      if (n == inj_n) begin
        multiplicand = ia;
        multiplier   = ib;
        start        = 1'b1;
      end else begin
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    prod  = product;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int inj_n, input logic [31:0] ia, input logic [31:0] ib);
    int lat, ov, bd, pm;
    logic [63:0] prod, exp;
    exp = ref_mul(a, b);
    run_op(a, b, inj_n, ia, ib, lat, prod, ov, bd, pm);
    total++;
    if (lat != WIDTH) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, WIDTH);
    end
    total++;
    if (prod !== exp) begin
      bad++;
      $display("FAIL %s product: got %h want %h", name, prod, exp);
    end
    total++;
    if (ov != 0 || bd != 0 || pm != 0) begin
      bad++;
      $display("FAIL %s handshake: overlap=%0d busy_drop=%0d prod_moved=%0d want all 0",
               name, ov, bd, pm);
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    check_op("basic_15x2", 32'h0000000F, 32'h00000002, -1, 0, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 64'h1E) begin
      bad++;
      $display("FAIL basic_hold: done=%b busy=%b product=%h want 0 0 1e", done, busy, product);
    end
    idle_gap();
    check_op("basic_16x2", 32'h00000010, 32'h00000002, -1, 0, 0);
    idle_gap();
    check_op("zero_a", 32'h0, 32'hFFFFFFFF, -1, 0, 0);
  endtask

  task automatic test_extremes();
    idle_gap();
    check_op("max_x_max", 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 0);
    total++;
    if (product !== 64'hFFFFFFFE00000001) begin
      bad++;
      $display("FAIL max_const: got %h want fffffffe00000001", product);
    end
    idle_gap();
    check_op("msb_x2", 32'h80000000, 32'h00000002, -1, 0, 0);
    idle_gap();
    check_op("zero_b", 32'hDEADBEEF, 32'h0, -1, 0, 0);
  endtask

  task automatic test_start_ignored();
    int extra;
    idle_gap();
    check_op("start_in_run", 32'd3, 32'd5, 10, 32'd7, 32'd7);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (extra != 0 || product !== 64'h0F) begin
      bad++;
      $display("FAIL start_in_run_no_requeue: active_cycles=%0d product=%h want 0 f", extra, product);
    end
  endtask

  task automatic test_back_to_back();
    idle_gap();
    check_op("b2b_first", 32'd6, 32'd7, -1, 0, 0);
    check_op("b2b_second", 32'd9, 32'd9, -1, 0, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || product !== 64'h51) begin
      bad++;
      $display("FAIL b2b_single_done: done=%b product=%h want 0 51", done, product);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    idle_gap();
    multiplicand = 32'h1234;
    multiplier   = 32'h10;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_async: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy || product !== 64'd0) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL reset_mid_abandon: active_cycles=%0d want 0", extra);
    end
    check_op("after_reset", 32'h1234, 32'h10, -1, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 3) a = a >> $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) idle_gap();
      check_op("random", a, b, -1, 0, 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    @(negedge clk);
    test_basic();
    test_extremes();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
